// File: rtl/lsu_mc.sv
// Multi-cycle load/store unit: one outstanding request, min 3 cycles accept->resp (1 cycle on error).
// Backpressure: req_ready only in IDLE; mem_* held until mem_ready; resp_* held until resp_ready.
module lsu_mc #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int REG_IDX_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_wen,
  input  logic [2:0]               req_func3,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  input  logic [REG_IDX_WIDTH-1:0] req_rd,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic                     mem_wen,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic [DATA_WIDTH/8-1:0]  mem_wmask,
  input  logic                     mem_rvalid,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic [REG_IDX_WIDTH-1:0] resp_rd,
  output logic                     resp_err
);

  localparam int STRB  = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(STRB);
  localparam logic [DATA_WIDTH-1:0] ONES = '1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t state, state_nxt;

  logic                     wen_q;
  logic [2:0]               func3_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [REG_IDX_WIDTH-1:0] rd_q;
  logic                     err_q;
  logic [DATA_WIDTH-1:0]    res_q;

  logic req_illegal, req_misalign, req_err, accept;

  // Request decode works on the live inputs so errors can skip the bus entirely.
  always_comb begin
    req_illegal = 1'b0;
    if (req_func3 == 3'b111)
      req_illegal = 1'b1;
    if (req_wen && req_func3[2])
      req_illegal = 1'b1;
    if ((req_func3 == 3'b011 || req_func3 == 3'b110) && DATA_WIDTH != 64)
      req_illegal = 1'b1;
    case (req_func3[1:0])
      2'b01:   req_misalign = req_addr[0];
      2'b10:   req_misalign = |req_addr[1:0];
      2'b11:   req_misalign = |req_addr[2:0];
      default: req_misalign = 1'b0;
    endcase
  end

  assign req_err = req_illegal | req_misalign;
  assign accept  = req_valid && (state == S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = req_err ? S_RESP : S_REQ;
      S_REQ:  if (mem_ready) state_nxt = S_WAIT;
      S_WAIT: if (mem_rvalid) state_nxt = S_RESP;
      S_RESP: if (resp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  logic [OFF_W-1:0]      off;
  logic [OFF_W+2:0]      sh_amt;
  logic [7:0]            size_mask;
  logic [STRB-1:0]       wmask_sh;
  logic [DATA_WIDTH-1:0] wdata_sh;
  logic [DATA_WIDTH-1:0] addr_aligned_pad;
  logic [DATA_WIDTH-1:0] rdata_sh, lmask, load_data;
  logic                  sbit;

  assign off      = addr_q[OFF_W-1:0];
  assign sh_amt   = {off, 3'b000};
  assign wdata_sh = wdata_q << sh_amt;
  assign wmask_sh = size_mask[STRB-1:0] << off;
  assign rdata_sh = mem_rdata >> sh_amt;
  assign addr_aligned_pad = '0;

  always_comb begin
    case (func3_q[1:0])
      2'b00:   begin size_mask = 8'h01; lmask = ONES >> (DATA_WIDTH - 8);  sbit = rdata_sh[7];  end
      2'b01:   begin size_mask = 8'h03; lmask = ONES >> (DATA_WIDTH - 16); sbit = rdata_sh[15]; end
      2'b10:   begin size_mask = 8'h0F; lmask = ONES >> (DATA_WIDTH - 32); sbit = rdata_sh[31]; end
      default: begin size_mask = 8'hFF; lmask = ONES;                      sbit = 1'b0;         end
    endcase
  end

  // func3[2] selects zero extension; doubleword has no bits left to extend.
  assign load_data = (rdata_sh & lmask) | ((!func3_q[2] && sbit) ? ~lmask : '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wen_q   <= 1'b0;
      func3_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
      res_q   <= '0;
    end else if (accept) begin
      wen_q   <= req_wen;
      func3_q <= req_func3;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      rd_q    <= req_rd;
      err_q   <= req_err;
      res_q   <= '0;
    end else if (state == S_WAIT && mem_rvalid) begin
      res_q <= wen_q ? '0 : load_data;
    end
  end

  always_comb begin
    req_ready  = 1'b0;
    mem_valid  = 1'b0;
    mem_wen    = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wmask  = '0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_rd    = '0;
    resp_err   = 1'b0;
    case (state)
      S_IDLE: req_ready = 1'b1;
      S_REQ: begin
        mem_valid = 1'b1;
        mem_wen   = wen_q;
        mem_addr  = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
        mem_wdata = wen_q ? wdata_sh : addr_aligned_pad;
        mem_wmask = wen_q ? wmask_sh : '0;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = res_q;
        resp_rd    = rd_q;
        resp_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule
